// File: rtl/spi_ram_slave_burst.sv
// SPI slave fronting a single-port RAM: address/data frames, burst read and write
// with optional pointer auto-increment, and a one-cycle abort flag for truncated frames.
module spi_ram_slave_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_abort
);

    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(SW) + 1;
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WR_ADDR, S_RD_ADDR, S_WR_DATA, S_TA, S_RD_OUT, S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [CW-1:0]           r_bitCnt;
    logic [SW-1:0]           r_shreg;
    logic                    r_cmdHi;
    logic [ADDR_WIDTH-1:0]   r_wrAddr;
    logic [ADDR_WIDTH-1:0]   r_rdAddr;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                    w_addrDone;
    logic                    w_wordDone;
    logic                    w_memWrite;
    logic                    w_loadWord;
    logic                    w_shiftOut;
    logic                    w_abort;
    logic                    w_wrInRange;
    logic                    w_rdInRange;
    logic [ADDR_WIDTH-1:0]   w_addrWord;
    logic [DATA_WIDTH-1:0]   w_wrWord;
    logic [DATA_WIDTH-1:0]   w_rdWord;

    // Pointer advance: out-of-range pointers and the last valid word both wrap to 0.
    function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] a);
        if (!AUTO_INC) return a;
        if ({1'b0, a} >= DEPTH_EXT - 1'b1) return '0;
        return a + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (SS_n) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_nextState = S_CMD;
                S_CMD: begin
                    if (r_bitCnt != '0) begin
                        case ({r_cmdHi, MOSI})
                            2'b00:   w_nextState = S_WR_ADDR;
                            2'b01:   w_nextState = S_WR_DATA;
                            2'b10:   w_nextState = S_RD_ADDR;
                            default: w_nextState = S_TA;
                        endcase
                    end
                end
                S_WR_ADDR, S_RD_ADDR: if (w_addrDone) w_nextState = S_DONE;
                S_TA:      w_nextState = S_RD_OUT;
                default:   w_nextState = r_state;
            endcase
        end
    end

    always_comb begin
        w_addrWord  = {r_shreg[ADDR_WIDTH-2:0], MOSI};
        w_wrWord    = {r_shreg[DATA_WIDTH-2:0], MOSI};
        w_wrInRange = {1'b0, r_wrAddr} < DEPTH_EXT;
        w_rdInRange = {1'b0, r_rdAddr} < DEPTH_EXT;
        w_rdWord    = '0;
        if (w_rdInRange) w_rdWord = r_mem[r_rdAddr[MW-1:0]];
        w_addrDone  = !SS_n && (r_state == S_WR_ADDR || r_state == S_RD_ADDR) && (r_bitCnt == ADDR_LAST);
        w_wordDone  = !SS_n && (r_state == S_WR_DATA) && (r_bitCnt == DATA_LAST);
        w_memWrite  = w_wordDone && w_wrInRange;
        w_loadWord  = !SS_n && ((r_state == S_TA) || (r_state == S_RD_OUT && r_bitCnt == DATA_LAST));
        w_shiftOut  = !SS_n && (r_state == S_RD_OUT) && (r_bitCnt != DATA_LAST);
        // Only frames cut off before a clean boundary count as aborted.
        w_abort     = SS_n && ((r_state == S_CMD) || (r_state == S_TA) ||
                               (r_state == S_WR_ADDR) || (r_state == S_RD_ADDR) ||
                               (r_state == S_WR_DATA && r_bitCnt != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MISO        <= 1'b0;
            frame_abort <= 1'b0;
            r_bitCnt    <= '0;
            r_shreg     <= '0;
            r_cmdHi     <= 1'b0;
            r_wrAddr    <= '0;
            r_rdAddr    <= '0;
        end else begin
            frame_abort <= w_abort;
            MISO        <= 1'b0;
            if (w_loadWord)      MISO <= w_rdWord[DATA_WIDTH-1];
            else if (w_shiftOut) MISO <= r_shreg[DATA_WIDTH-2];

            if (w_addrDone && r_state == S_WR_ADDR) r_wrAddr <= w_addrWord;
            else if (w_wordDone)                    r_wrAddr <= nextAddr(r_wrAddr);

            if (w_addrDone && r_state == S_RD_ADDR) r_rdAddr <= w_addrWord;
            else if (w_loadWord)                    r_rdAddr <= nextAddr(r_rdAddr);

            if (SS_n) begin
                r_bitCnt <= '0;
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (r_bitCnt == '0) begin
                            r_cmdHi  <= MOSI;
                            r_bitCnt <= CW'(1);
                        end else begin
                            r_bitCnt <= '0;
                        end
                    end
                    S_WR_ADDR, S_RD_ADDR, S_WR_DATA: begin
                        r_shreg  <= {r_shreg[SW-2:0], MOSI};
                        r_bitCnt <= (w_addrDone || w_wordDone) ? '0 : r_bitCnt + 1'b1;
                    end
                    S_TA, S_RD_OUT: begin
                        if (w_loadWord) begin
                            r_shreg  <= SW'(w_rdWord);
                            r_bitCnt <= '0;
                        end else begin
                            r_shreg  <= r_shreg << 1;
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                    default: r_bitCnt <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_memWrite) r_mem[r_wrAddr[MW-1:0]] <= w_wrWord;
    end

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Bench for spi_ram_slave_burst: a default 8/8/256 auto-increment instance and a
// 10/16/1000 fixed-pointer instance, both compared against a word-level RAM model.
module tb_spi_ram_slave_burst;

    logic clk = 1'b0;
    logic rst_n;
    logic ssA, mosiA, misoA, abortA;
    logic ssB, mosiB, misoB, abortB;

    int nTests = 0;
    int nFail  = 0;

    int aw    [2] = '{8, 10};
    int dw    [2] = '{8, 16};
    int depth [2] = '{256, 1000};
    int inc   [2] = '{1, 0};

    logic [15:0] mdlMem   [2][1024];
    bit          mdlKnown [2][1024];
    int          wrPtr [2];
    int          rdPtr [2];

    always #5 clk = ~clk;

    spi_ram_slave_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) dutA (
        .clk(clk), .rst_n(rst_n), .SS_n(ssA), .MOSI(mosiA), .MISO(misoA), .frame_abort(abortA));

    spi_ram_slave_burst #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .MEM_DEPTH(1000), .AUTO_INC(1'b0)) dutB (
        .clk(clk), .rst_n(rst_n), .SS_n(ssB), .MOSI(mosiB), .MISO(misoB), .frame_abort(abortB));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nTests++;
        if (observed !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic misoOf(input int inst);
        return (inst == 0) ? misoA : misoB;
    endfunction

    function automatic logic abortOf(input int inst);
        return (inst == 0) ? abortA : abortB;
    endfunction

    function automatic int modelInc(input int inst, input int p);
        if (inc[inst] == 0) return p;
        return (p + 1 >= depth[inst]) ? 0 : p + 1;
    endfunction

    // One bit-cycle: drive after a falling edge, let the rising edge sample, return at the next falling edge.
    task automatic applyStimulus(input int inst, input logic ss, input logic mosi);
        if (inst == 0) begin ssA = ss; mosiA = mosi; end
        else           begin ssB = ss; mosiB = mosi; end
        @(negedge clk);
    endtask

    task automatic endFrame(input int inst, input logic expAbort, input string tag);
        applyStimulus(inst, 1'b1, 1'b0);
        checkOutput({tag, " abort"}, 64'(abortOf(inst)), 64'(expAbort));
        checkOutput({tag, " miso idle"}, 64'(misoOf(inst)), 64'd0);
        applyStimulus(inst, 1'b1, 1'b0);
        checkOutput({tag, " abort width"}, 64'(abortOf(inst)), 64'd0);
    endtask

    task automatic sendCmd(input int inst, input logic [1:0] cmd);
        applyStimulus(inst, 1'b0, rbit());
        applyStimulus(inst, 1'b0, cmd[1]);
        applyStimulus(inst, 1'b0, cmd[0]);
    endtask

    task automatic addrFrame(input int inst, input logic isRd, input int addr, input int nBits, input string tag);
        logic [31:0] a;
        a = addr;
        sendCmd(inst, {isRd, 1'b0});
        for (int i = 0; i < nBits; i++) applyStimulus(inst, 1'b0, a[aw[inst]-1-i]);
        if (nBits == aw[inst]) begin
            if (isRd) rdPtr[inst] = addr;
            else      wrPtr[inst] = addr;
            repeat ($urandom_range(3, 0)) applyStimulus(inst, 1'b0, rbit());
        end
        endFrame(inst, nBits < aw[inst], tag);
    endtask

    task automatic dataWriteFrame(input int inst, input logic [15:0] words[$], input int extraBits, input string tag);
        sendCmd(inst, 2'b01);
        foreach (words[j]) begin
            for (int b = 0; b < dw[inst]; b++) applyStimulus(inst, 1'b0, words[j][dw[inst]-1-b]);
            if (wrPtr[inst] < depth[inst]) begin
                mdlMem[inst][wrPtr[inst]]   = words[j];
                mdlKnown[inst][wrPtr[inst]] = 1'b1;
            end
            wrPtr[inst] = modelInc(inst, wrPtr[inst]);
        end
        for (int b = 0; b < extraBits; b++) applyStimulus(inst, 1'b0, rbit());
        endFrame(inst, (extraBits % dw[inst]) != 0, tag);
    endtask

    task automatic dataReadFrame(input int inst, input int nWords, input string tag);
        logic [63:0] got;
        logic [63:0] exp;
        bit          known;
        sendCmd(inst, 2'b11);
        checkOutput({tag, " turnaround miso"}, 64'(misoOf(inst)), 64'd0);
        for (int w = 0; w < nWords; w++) begin
            known = (rdPtr[inst] >= depth[inst]) || mdlKnown[inst][rdPtr[inst]];
            exp   = (rdPtr[inst] < depth[inst]) ? 64'(mdlMem[inst][rdPtr[inst]]) : 64'd0;
            rdPtr[inst] = modelInc(inst, rdPtr[inst]);
            got = '0;
            for (int b = 0; b < dw[inst]; b++) begin
                applyStimulus(inst, 1'b0, rbit());
                got = (got << 1) | 64'(misoOf(inst));
            end
            if (known) checkOutput({tag, " word"}, got, exp);
        end
        endFrame(inst, nWords == 0, tag);
    endtask

    initial begin
        logic [15:0] q[$];
        rst_n = 1'b0;
        ssA = 1'b1; mosiA = 1'b0;
        ssB = 1'b1; mosiB = 1'b0;
        for (int i = 0; i < 2; i++) begin wrPtr[i] = 0; rdPtr[i] = 0; end
        repeat (3) @(negedge clk);
        checkOutput("reset misoA", 64'(misoA), 64'd0);
        checkOutput("reset abortA", 64'(abortA), 64'd0);
        checkOutput("reset misoB", 64'(misoB), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both pointers start at 0: a bare write then a bare read must meet at word 0.
        q = '{16'h00A7};
        dataWriteFrame(0, q, 0, "reset wr ptr");
        dataReadFrame(0, 1, "reset rd ptr");

        q = '{};
        for (int i = 0; i < 256; i++) q.push_back(16'($urandom_range(255, 0)));
        addrFrame(0, 1'b0, 0, 8, "init wr_addr");
        dataWriteFrame(0, q, 0, "init fill");

        addrFrame(0, 1'b0, 'h5A, 8, "t1 wr_addr");
        q = '{16'h00C3};
        dataWriteFrame(0, q, 0, "t1 wr_data");
        addrFrame(0, 1'b1, 'h5A, 8, "t1 rd_addr");
        dataReadFrame(0, 1, "t1 rd_data");

        addrFrame(0, 1'b0, 'hFE, 8, "t2 wr_addr");
        q = '{16'h0011, 16'h0022, 16'h0033};
        dataWriteFrame(0, q, 0, "t2 burst wr");
        addrFrame(0, 1'b1, 'hFE, 8, "t3 rd_addr");
        dataReadFrame(0, 3, "t3 burst rd");
        q = '{16'h0044};
        dataWriteFrame(0, q, 0, "t2 wr ptr wrap");
        dataReadFrame(0, 1, "t3 rd ptr wrap");

        addrFrame(0, 1'b0, 'h10, 8, "t4 wr_addr");
        q = '{};
        dataWriteFrame(0, q, 4, "t4 partial wr");
        addrFrame(0, 1'b1, 'h10, 8, "t4 rd_addr");
        dataReadFrame(0, 1, "t4 mem kept");
        q = '{16'h0055};
        dataWriteFrame(0, q, 0, "t4 wr ptr kept");
        addrFrame(0, 1'b1, 'h10, 8, "t4 rd_addr2");
        dataReadFrame(0, 1, "t4 rd new");

        applyStimulus(0, 1'b0, 1'b0);
        endFrame(0, 1'b1, "start only");
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1);
        endFrame(0, 1'b1, "one cmd bit");
        addrFrame(0, 1'b0, 'h33, 3, "short wr_addr");
        addrFrame(0, 1'b1, 'h33, 0, "empty rd_addr");
        q = '{};
        dataWriteFrame(0, q, 0, "empty wr_data");
        dataReadFrame(0, 0, "empty rd_data");

        // Reset in the middle of a read burst.
        addrFrame(0, 1'b1, 'h5A, 8, "t5 rd_addr");
        sendCmd(0, 2'b11);
        repeat (3) applyStimulus(0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5 reset miso", 64'(misoA), 64'd0);
        checkOutput("t5 reset abort", 64'(abortA), 64'd0);
        ssA = 1'b1;
        for (int i = 0; i < 2; i++) begin wrPtr[i] = 0; rdPtr[i] = 0; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q = '{16'h0096};
        dataWriteFrame(0, q, 0, "t5 wr ptr");
        dataReadFrame(0, 1, "t5 rd ptr");
        addrFrame(0, 1'b0, 'h5A, 8, "t5 t1 wr_addr");
        q = '{16'h00C3};
        dataWriteFrame(0, q, 0, "t5 t1 wr_data");
        addrFrame(0, 1'b1, 'h5A, 8, "t5 t1 rd_addr");
        dataReadFrame(0, 1, "t5 t1 rd_data");

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(5, 0))
                0: addrFrame(0, 1'b0, int'($urandom_range(255, 0)), 8, "rnd wr_addr");
                1: addrFrame(0, 1'b1, int'($urandom_range(255, 0)), 8, "rnd rd_addr");
                2: begin
                    q = '{};
                    repeat ($urandom_range(4, 1)) q.push_back(16'($urandom_range(255, 0)));
                    dataWriteFrame(0, q, ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0, "rnd wr_data");
                end
                3: dataReadFrame(0, int'($urandom_range(4, 0)), "rnd rd_data");
                4: addrFrame(0, rbit(), 0, int'($urandom_range(7, 0)), "rnd short addr");
                default: begin
                    applyStimulus(0, 1'b0, rbit());
                    if (rbit()) applyStimulus(0, 1'b0, rbit());
                    endFrame(0, 1'b1, "rnd cmd cut");
                end
            endcase
        end

        addrFrame(1, 1'b0, 999, 10, "t6 wr_addr 999");
        q = '{16'hBEEF, 16'h1234};
        dataWriteFrame(1, q, 0, "t6 burst wr");
        addrFrame(1, 1'b1, 999, 10, "t6 rd_addr 999");
        dataReadFrame(1, 2, "t6 rd 999");
        addrFrame(1, 1'b0, 1000, 10, "t6 wr_addr 1000");
        q = '{16'hABCD};
        dataWriteFrame(1, q, 0, "t6 wr oor");
        addrFrame(1, 1'b1, 1000, 10, "t6 rd_addr 1000");
        dataReadFrame(1, 1, "t6 rd oor");
        addrFrame(1, 1'b1, 1023, 10, "t6 rd_addr 1023");
        dataReadFrame(1, 1, "t6 rd top");
        addrFrame(1, 1'b0, 998, 10, "t6 wr_addr 998");
        q = '{16'($urandom_range(65535, 0))};
        dataWriteFrame(1, q, 9, "t6 wr partial");
        addrFrame(1, 1'b1, 998, 10, "t6 rd_addr 998");
        dataReadFrame(1, 2, "t6 rd 998");
        addrFrame(1, 1'b1, 999, 10, "t6 rd_addr 999b");
        dataReadFrame(1, 1, "t6 rd 999b");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
